// File: rtl/dcsc_pkg.sv
// Shared types and helpers for the DCC/DCS clock changeover controller.
package dcsc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATE_OFF,
    ST_SWITCH,
    ST_SETTLE,
    ST_GATE_ON,
    ST_DONE
  } dcsc_state_t;

  localparam logic DCSC_BR0 = 1'b0;
  localparam logic DCSC_BR1 = 1'b1;

  // Width needed to hold the larger of the two wait lengths.
  function automatic int dcsc_timer_w(input int gate_cycles, input int settle_cycles);
    int max_c;
    int w;
    max_c = (gate_cycles > settle_cycles) ? gate_cycles : settle_cycles;
    w = $clog2(max_c + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dcsc_wait_timer.sv
// Loadable down-counter used for both the gate-off and settle waits.
// expired is high on the last cycle of a loaded wait, so a load of N
// keeps the controller in the waiting state for exactly N cycles.
module dcsc_wait_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count_reg;

  // Load takes priority; otherwise count down and rest at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = (count_reg <= W'(1));

endmodule

// File: rtl/dcs_switch_ctrl.sv
// Glitch-free changeover sequencer for two DCC-gated clock branches feeding a DCS.
// Optional feature macro: DCSC_SWCOUNT_EN adds the saturating sw_count output.
// All outputs are registered from the next-state decode, so they change in the
// same cycle the state they belong to becomes current.
module dcs_switch_ctrl
  import dcsc_pkg::*;
#(
  parameter int GATE_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_sel,
  output logic             req_ready,
  output logic             done,
  output logic             busy,
  output logic             cur_sel,
  output logic             dcc_ce0,
  output logic             dcc_ce1,
  output logic             dcs_sel
`ifdef DCSC_SWCOUNT_EN
  ,
  output logic [CNT_W-1:0] sw_count
`endif
);

  localparam int TW = dcsc_timer_w(GATE_CYCLES, SETTLE_CYCLES);

  // A zero-length wait would let the select move with a CE still high.
  generate
    if (GATE_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_param
      $error("dcs_switch_ctrl: GATE_CYCLES and SETTLE_CYCLES must be >= 1");
    end
  endgenerate

  dcsc_state_t state_reg, state_next;
  logic        target_reg, target_next;
  logic        timer_load;
  logic [TW-1:0] timer_value;
  logic        timer_expired;

  logic req_ready_reg, done_reg, busy_reg, cur_sel_reg;
  logic ce0_reg, ce1_reg, dcs_sel_reg;
  logic req_ready_next, done_next, busy_next, cur_sel_next;
  logic ce0_next, ce1_next, dcs_sel_next;

  dcsc_wait_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  // State, latched target and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      target_reg    <= DCSC_BR0;
      req_ready_reg <= 1'b1;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      cur_sel_reg   <= DCSC_BR0;
      ce0_reg       <= 1'b1;
      ce1_reg       <= 1'b0;
      dcs_sel_reg   <= DCSC_BR0;
    end else begin
      state_reg     <= state_next;
      target_reg    <= target_next;
      req_ready_reg <= req_ready_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
      cur_sel_reg   <= cur_sel_next;
      ce0_reg       <= ce0_next;
      ce1_reg       <= ce1_next;
      dcs_sel_reg   <= dcs_sel_next;
    end
  end

  // Next-state sequencing and timer control; requests are only seen in IDLE.
  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          target_next = req_sel;
          if (req_sel == cur_sel_reg) begin
            state_next = ST_DONE;
          end else begin
            state_next  = ST_GATE_OFF;
            timer_load  = 1'b1;
            timer_value = TW'(GATE_CYCLES);
          end
        end
      end
      ST_GATE_OFF: begin
        if (timer_expired) state_next = ST_SWITCH;
      end
      ST_SWITCH: begin
        state_next  = ST_SETTLE;
        timer_load  = 1'b1;
        timer_value = TW'(SETTLE_CYCLES);
      end
      ST_SETTLE: begin
        if (timer_expired) state_next = ST_GATE_ON;
      end
      ST_GATE_ON: state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Output decode from the state being entered; CEs/select hold otherwise.
  always_comb begin
    req_ready_next = (state_next == ST_IDLE);
    busy_next      = (state_next != ST_IDLE);
    done_next      = (state_next == ST_DONE);
    cur_sel_next   = cur_sel_reg;
    ce0_next       = ce0_reg;
    ce1_next       = ce1_reg;
    dcs_sel_next   = dcs_sel_reg;
    case (state_next)
      ST_GATE_OFF: begin
        ce0_next = 1'b0;
        ce1_next = 1'b0;
      end
      ST_SWITCH: dcs_sel_next = target_next;
      ST_GATE_ON: begin
        ce0_next     = (target_next == DCSC_BR0);
        ce1_next     = (target_next == DCSC_BR1);
        cur_sel_next = target_next;
      end
      default: ;
    endcase
  end

`ifdef DCSC_SWCOUNT_EN
  logic [CNT_W-1:0] sw_count_reg;

  // Count real switches as the new branch is enabled, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_count_reg <= '0;
    end else if (state_next == ST_GATE_ON && sw_count_reg != '1) begin
      sw_count_reg <= sw_count_reg + 1'b1;
    end
  end

  assign sw_count = sw_count_reg;
`endif

  assign req_ready = req_ready_reg;
  assign done      = done_reg;
  assign busy      = busy_reg;
  assign cur_sel   = cur_sel_reg;
  assign dcc_ce0   = ce0_reg;
  assign dcc_ce1   = ce1_reg;
  assign dcs_sel   = dcs_sel_reg;

endmodule

// File: tb/tb_dcs_switch_ctrl.sv
// Directed bench for dcs_switch_ctrl (G=4, S=2, CNT_W=2).
// Build with DCSC_SWCOUNT_EN defined to also exercise the switch counter.
module tb_dcs_switch_ctrl;

  logic clk;
  logic rst;
  logic req_valid;
  logic req_sel;
  logic req_ready, done, busy, cur_sel, dcc_ce0, dcc_ce1, dcs_sel;
`ifdef DCSC_SWCOUNT_EN
  logic [1:0] sw_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  logic viol_ce = 1'b0;
  logic viol_sel = 1'b0;
  logic prev_dcs_sel = 1'b0;
  logic prev_rst = 1'b1;

  dcs_switch_ctrl #(
    .GATE_CYCLES   (4),
    .SETTLE_CYCLES (2),
    .CNT_W         (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .done      (done),
    .busy      (busy),
    .cur_sel   (cur_sel),
    .dcc_ce0   (dcc_ce0),
    .dcc_ce1   (dcc_ce1),
    .dcs_sel   (dcs_sel)
`ifdef DCSC_SWCOUNT_EN
    ,
    .sw_count  (sw_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Invariant monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (dcc_ce0 && dcc_ce1) viol_ce = 1'b1;
    if (!prev_rst && (dcs_sel !== prev_dcs_sel) && (dcc_ce0 || dcc_ce1)) viol_sel = 1'b1;
    prev_dcs_sel = dcs_sel;
    prev_rst = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Issue one request from IDLE and wait (bounded) for done, then return to IDLE.
  task automatic do_switch(input logic sel, input string tag);
    int k;
    req_valid = 1'b1;
    req_sel   = sel;
    step();
    req_valid = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    step();
  endtask

  initial begin
    logic [4:0] sels;
    logic [1:0] exp_cnt [5];
    rst = 1'b1;
    req_valid = 1'b0;
    req_sel = 1'b0;
    #1;

    // 1: reset values
    step();
    step();
    rst = 1'b0;
    chk("rst_ce0", dcc_ce0, 1);
    chk("rst_ce1", dcc_ce1, 0);
    chk("rst_dcs_sel", dcs_sel, 0);
    chk("rst_cur_sel", cur_sel, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
`ifdef DCSC_SWCOUNT_EN
    chk("rst_sw_count", sw_count, 0);
`endif
    $display("txn reset: ce0=%0b ce1=%0b dcs_sel=%0b cur_sel=%0b", dcc_ce0, dcc_ce1, dcs_sel, cur_sel);

    // 3: same-select request completes in one cycle with no activity
    req_valid = 1'b1;
    req_sel = 1'b0;
    step();
    req_valid = 1'b0;
    chk("same_done_n1", done, 1);
    chk("same_ce0", dcc_ce0, 1);
    chk("same_ce1", dcc_ce1, 0);
    chk("same_dcs_sel", dcs_sel, 0);
    chk("same_ready_n1", req_ready, 0);
    step();
    chk("same_done_n2", done, 0);
    chk("same_ready_n2", req_ready, 1);
`ifdef DCSC_SWCOUNT_EN
    chk("same_sw_count", sw_count, 0);
`endif
    $display("txn same-select 0->0: done pulse at N+1");

    // 2: real switch 0->1, cycle-exact timeline
    chk("sw1_ready_n", req_ready, 1);
    req_valid = 1'b1;
    req_sel = 1'b1;
    step();
    req_valid = 1'b0;
    req_sel = 1'b0;
    chk("sw1_ce0_n1", dcc_ce0, 0);
    chk("sw1_ce1_n1", dcc_ce1, 0);
    chk("sw1_busy_n1", busy, 1);
    step(); step(); step();
    chk("sw1_dcs_n4", dcs_sel, 0);
    step();
    chk("sw1_dcs_n5", dcs_sel, 1);
    chk("sw1_ce1_n5", dcc_ce1, 0);
    step(); step();
    chk("sw1_ce1_n7", dcc_ce1, 0);
    chk("sw1_done_n7", done, 0);
    step();
    chk("sw1_ce1_n8", dcc_ce1, 1);
    chk("sw1_ce0_n8", dcc_ce0, 0);
    chk("sw1_cur_n8", cur_sel, 1);
    chk("sw1_done_n8", done, 0);
    step();
    chk("sw1_done_n9", done, 1);
    chk("sw1_ready_n9", req_ready, 0);
    step();
    chk("sw1_done_n10", done, 0);
    chk("sw1_ready_n10", req_ready, 1);
    chk("sw1_busy_n10", busy, 0);
    $display("txn switch 0->1: ce1=%0b cur_sel=%0b dcs_sel=%0b", dcc_ce1, cur_sel, dcs_sel);

    // 4: req_valid held, req_sel wiggling during busy; target 0 latched
    req_valid = 1'b1;
    req_sel = 1'b0;
    step();
    for (int k = 1; k <= 9; k++) begin
      req_sel = (k == 2 || k == 6) ? 1'b0 : 1'b1;
      chk($sformatf("hold_ready_n%0d", k), req_ready, 0);
      if (k == 5) chk("hold_dcs_n5", dcs_sel, 0);
      if (k == 8) begin
        chk("hold_cur_n8", cur_sel, 0);
        chk("hold_ce0_n8", dcc_ce0, 1);
        chk("hold_ce1_n8", dcc_ce1, 0);
      end
      if (k == 9) chk("hold_done_n9", done, 1);
      step();
    end
    chk("hold_ready_n10", req_ready, 1);
    $display("txn switch 1->0 with held valid: cur_sel=%0b", cur_sel);

    // Second request accepted at N+10 (0->1), then 5: reset in GATE_OFF
    req_sel = 1'b1;
    step();
    req_valid = 1'b0;
    chk("acc2_busy_m1", busy, 1);
    chk("acc2_ce0_m1", dcc_ce0, 0);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ce0", dcc_ce0, 1);
    chk("midrst_ce1", dcc_ce1, 0);
    chk("midrst_dcs", dcs_sel, 0);
    chk("midrst_cur", cur_sel, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_busy", busy, 0);
    $display("txn reset in GATE_OFF: ce0=%0b ready=%0b", dcc_ce0, req_ready);

    // 6: five alternating switches; counter saturates at 3
    sels = 5'b10101;
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
    exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      do_switch(sels[i], $sformatf("alt%0d", i));
      chk($sformatf("alt%0d_cur", i), cur_sel, sels[i]);
`ifdef DCSC_SWCOUNT_EN
      chk($sformatf("alt%0d_sw_count", i), sw_count, exp_cnt[i]);
`endif
      $display("txn alternate switch %0d to %0b: cur_sel=%0b", i, sels[i], cur_sel);
    end

    chk("inv_ce_exclusive", viol_ce, 0);
    chk("inv_dcs_sel_gated", viol_sel, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
